// File: rtl/pmp_checker.sv
// Sequential physical-memory-protection checker: scans the 16 PMP entries one
// per clock, reports the first matching entry and whether the access is allowed.
module pmp_checker (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_type,
   input  logic [1:0]  priv_mode,
   input  logic [31:0] pmpcfg0,
   input  logic [31:0] pmpcfg1,
   input  logic [31:0] pmpcfg2,
   input  logic [31:0] pmpcfg3,
   input  logic [31:0] pmpaddr0,
   input  logic [31:0] pmpaddr1,
   input  logic [31:0] pmpaddr2,
   input  logic [31:0] pmpaddr3,
   input  logic [31:0] pmpaddr4,
   input  logic [31:0] pmpaddr5,
   input  logic [31:0] pmpaddr6,
   input  logic [31:0] pmpaddr7,
   input  logic [31:0] pmpaddr8,
   input  logic [31:0] pmpaddr9,
   input  logic [31:0] pmpaddr10,
   input  logic [31:0] pmpaddr11,
   input  logic [31:0] pmpaddr12,
   input  logic [31:0] pmpaddr13,
   input  logic [31:0] pmpaddr14,
   input  logic [31:0] pmpaddr15,
   input  logic        flush,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic        resp_allow,
   output logic        resp_hit,
   output logic [3:0]  resp_idx
);

   typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

   state_t      state, state_next;
   logic [3:0]  scan_idx;
   logic [31:0] cap_addr;
   logic [1:0]  cap_type;
   logic [1:0]  cap_priv;

   logic [127:0] pmpcfg_all;
   logic [511:0] pmpaddr_all;
   logic [7:0]   cur_cfg;
   logic [31:0]  cur_addr;
   logic [31:0]  lower_addr;
   logic [3:0]   prev_idx;
   logic [31:0]  word_addr;
   logic [31:0]  napot_mask;
   logic         entry_match;
   logic         perm;
   logic         hit_allow;
   logic         miss_allow;
   logic         accept;
   logic         last_entry;
   logic         unused_bits;

   assign pmpcfg_all  = {pmpcfg3, pmpcfg2, pmpcfg1, pmpcfg0};
   assign pmpaddr_all = {pmpaddr15, pmpaddr14, pmpaddr13, pmpaddr12,
                         pmpaddr11, pmpaddr10, pmpaddr9,  pmpaddr8,
                         pmpaddr7,  pmpaddr6,  pmpaddr5,  pmpaddr4,
                         pmpaddr3,  pmpaddr2,  pmpaddr1,  pmpaddr0};

   // Entry fields come straight from the live CSR inputs at the current index
   assign prev_idx   = scan_idx - 4'd1;
   assign cur_cfg    = pmpcfg_all[{scan_idx, 3'b000} +: 8];
   assign cur_addr   = pmpaddr_all[{scan_idx, 5'b00000} +: 32];
   assign lower_addr = (scan_idx == 4'd0) ? 32'd0 : pmpaddr_all[{prev_idx, 5'b00000} +: 32];
   assign word_addr  = {2'b00, cap_addr[31:2]};
   assign napot_mask = cur_addr ^ (cur_addr + 32'd1);

   always_comb begin
      entry_match = 1'b0;
      case (cur_cfg[4:3])
         2'd1:    entry_match = (word_addr >= lower_addr) && (word_addr < cur_addr);
         2'd2:    entry_match = (word_addr == cur_addr);
         2'd3:    entry_match = ((word_addr & ~napot_mask) == (cur_addr & ~napot_mask));
         default: entry_match = 1'b0;
      endcase
   end

   always_comb begin
      perm = 1'b0;
      case (cap_type)
         2'b00:   perm = cur_cfg[0];
         2'b01:   perm = cur_cfg[1];
         2'b10:   perm = cur_cfg[2];
         default: perm = 1'b0;
      endcase
   end

   // Machine mode bypasses unlocked entries; an illegal access type is never allowed
   assign hit_allow  = (cap_type != 2'b11) && (((cap_priv == 2'b11) && !cur_cfg[7]) || perm);
   assign miss_allow = (cap_type != 2'b11) && (cap_priv == 2'b11);

   assign accept     = (state == IDLE) && req_valid && !flush;
   assign last_entry = (scan_idx == 4'd15);
   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);

   assign unused_bits = ^{cap_addr[1:0], cur_cfg[6:5]};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = SCAN;
         SCAN: begin
            if (flush)                          state_next = IDLE;
            else if (entry_match || last_entry) state_next = RESP;
         end
         RESP: begin
            if (flush || resp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         scan_idx   <= 4'd0;
         cap_addr   <= 32'd0;
         cap_type   <= 2'd0;
         cap_priv   <= 2'd0;
         resp_allow <= 1'b0;
         resp_hit   <= 1'b0;
         resp_idx   <= 4'd0;
      end else begin
         if (accept) begin
            scan_idx <= 4'd0;
            cap_addr <= req_addr;
            cap_type <= req_type;
            cap_priv <= priv_mode;
         end else if (state == SCAN && !flush) begin
            if (entry_match) begin
               resp_hit   <= 1'b1;
               resp_idx   <= scan_idx;
               resp_allow <= hit_allow;
            end else if (last_entry) begin
               resp_hit   <= 1'b0;
               resp_idx   <= 4'd0;
               resp_allow <= miss_allow;
            end else begin
               scan_idx <= scan_idx + 4'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_pmp_checker.sv
// Scoreboard bench for pmp_checker: expected responses are queued when a
// request is driven and compared when the checker raises resp_valid.
module tb_pmp_checker;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid, req_ready;
   logic [31:0] req_addr;
   logic [1:0]  req_type, priv_mode;
   logic [31:0] pmpcfg [4];
   logic [31:0] pmpaddr [16];
   logic        flush;
   logic        resp_valid, resp_ready, resp_allow, resp_hit;
   logic [3:0]  resp_idx;

   typedef struct {
      logic       hit;
      logic [3:0] idx;
      logic       allow;
      int         lat;
   } exp_t;

   exp_t expQ[$];
   int   compared   = 0;
   int   mismatched = 0;

   pmp_checker dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_type(req_type), .priv_mode(priv_mode),
      .pmpcfg0(pmpcfg[0]), .pmpcfg1(pmpcfg[1]), .pmpcfg2(pmpcfg[2]), .pmpcfg3(pmpcfg[3]),
      .pmpaddr0(pmpaddr[0]),   .pmpaddr1(pmpaddr[1]),   .pmpaddr2(pmpaddr[2]),   .pmpaddr3(pmpaddr[3]),
      .pmpaddr4(pmpaddr[4]),   .pmpaddr5(pmpaddr[5]),   .pmpaddr6(pmpaddr[6]),   .pmpaddr7(pmpaddr[7]),
      .pmpaddr8(pmpaddr[8]),   .pmpaddr9(pmpaddr[9]),   .pmpaddr10(pmpaddr[10]), .pmpaddr11(pmpaddr[11]),
      .pmpaddr12(pmpaddr[12]), .pmpaddr13(pmpaddr[13]), .pmpaddr14(pmpaddr[14]), .pmpaddr15(pmpaddr[15]),
      .flush(flush),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_allow(resp_allow), .resp_hit(resp_hit), .resp_idx(resp_idx)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic clearCsrs();
      for (int i = 0; i < 4; i++)  pmpcfg[i]  = 32'd0;
      for (int i = 0; i < 16; i++) pmpaddr[i] = 32'd0;
   endtask

   // Drive one request, wait for its response, optionally stall it, then consume it
   task automatic applyStimulus(input string tag, input logic [31:0] addr, input logic [1:0] rtype,
                                input logic [1:0] priv, input logic exp_hit, input logic [3:0] exp_idx,
                                input logic exp_allow, input int hold, input logic keep_valid);
      exp_t e;
      exp_t got;
      int   lat;
      e.hit   = exp_hit;
      e.idx   = exp_idx;
      e.allow = exp_allow;
      e.lat   = exp_hit ? int'(exp_idx) + 1 : 16;
      expQ.push_back(e);
      @(negedge clock);
      req_addr  = addr;
      req_type  = rtype;
      priv_mode = priv;
      req_valid = 1'b1;
      checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      @(posedge clock);
      #1 req_valid = 1'b0;
      lat = 0;
      do begin
         @(posedge clock);
         #1 lat++;
      end while (!resp_valid && lat < 40);
      if (!resp_valid) begin
         checkOutput({tag, "_timeout"}, 32'(resp_valid), 32'd1);
         void'(expQ.pop_front());
         return;
      end
      got = expQ.pop_front();
      checkOutput({tag, "_latency"}, 32'(lat), 32'(got.lat));
      checkOutput({tag, "_hit"},     32'(resp_hit), 32'(got.hit));
      checkOutput({tag, "_idx"},     32'(resp_idx), 32'(got.idx));
      checkOutput({tag, "_allow"},   32'(resp_allow), 32'(got.allow));
      if (keep_valid) req_valid = 1'b1;
      for (int c = 0; c < hold; c++) begin
         @(posedge clock);
         #1;
         checkOutput({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
         checkOutput({tag, "_hold_data"},  {28'd0, resp_hit, resp_idx, resp_allow} & 32'h3F,
                                           {26'd0, got.hit, got.idx, got.allow});
         checkOutput({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
      end
      @(negedge clock);
      resp_ready = 1'b1;
      @(posedge clock);
      #1 resp_ready = 1'b0;
      checkOutput({tag, "_done_valid"}, 32'(resp_valid), 32'd0);
      checkOutput({tag, "_done_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b0;
   endtask

   initial begin
      int seen;
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_addr   = 32'd0;
      req_type   = 2'd0;
      priv_mode  = 2'd0;
      flush      = 1'b0;
      resp_ready = 1'b0;
      clearCsrs();
      #3;
      checkOutput("rst_ready", 32'(req_ready), 32'd1);
      checkOutput("rst_resp",  {28'd0, resp_valid, resp_hit, resp_allow, 1'b0} | 32'(resp_idx), 32'd0);
      @(negedge clock);
      reset = 1'b0;

      // NA4 on entry 2
      clearCsrs();
      pmpcfg[0]  = 32'h0011_0000;
      pmpaddr[2] = 32'h0000_0400;
      applyStimulus("na4_rd", 32'h1000, 2'b00, 2'b00, 1'b1, 4'd2, 1'b1, 0, 1'b0);
      applyStimulus("na4_wr", 32'h1000, 2'b01, 2'b00, 1'b1, 4'd2, 1'b0, 0, 1'b0);
      applyStimulus("na4_ill", 32'h1000, 2'b11, 2'b11, 1'b1, 4'd2, 1'b0, 0, 1'b0);

      // TOR on entry 1, bounded by entry 0
      clearCsrs();
      pmpaddr[0] = 32'h400;
      pmpaddr[1] = 32'h800;
      pmpcfg[0]  = 32'h0000_0C00;
      applyStimulus("tor_in",   32'h1FFC, 2'b10, 2'b00, 1'b1, 4'd1, 1'b1, 0, 1'b0);
      applyStimulus("tor_lo",   32'h1000, 2'b10, 2'b00, 1'b1, 4'd1, 1'b1, 0, 1'b0);
      applyStimulus("tor_out0", 32'h2000, 2'b10, 2'b00, 1'b0, 4'd0, 1'b0, 0, 1'b0);
      applyStimulus("tor_out3", 32'h2000, 2'b10, 2'b11, 1'b0, 4'd0, 1'b1, 0, 1'b0);
      applyStimulus("tor_below", 32'h0FFC, 2'b10, 2'b00, 1'b0, 4'd0, 1'b0, 0, 1'b0);

      // Locked NAPOT on entry 4 in machine mode
      clearCsrs();
      pmpaddr[4] = 32'h0000_23FF;
      pmpcfg[1]  = 32'h0000_0098;
      applyStimulus("napot_in",  32'h9FFC, 2'b00, 2'b11, 1'b1, 4'd4, 1'b0, 0, 1'b0);
      applyStimulus("napot_base", 32'h8000, 2'b00, 2'b11, 1'b1, 4'd4, 1'b0, 0, 1'b0);
      applyStimulus("napot_out", 32'hA000, 2'b00, 2'b11, 1'b0, 4'd0, 1'b1, 0, 1'b0);

      // All-ones NAPOT on the last entry matches anything
      clearCsrs();
      pmpaddr[15] = 32'hFFFF_FFFF;
      pmpcfg[3]   = 32'h1F00_0000;
      applyStimulus("napot_all", 32'hDEAD_BEEC, 2'b01, 2'b01, 1'b1, 4'd15, 1'b1, 0, 1'b0);

      // Priority and backpressure with a pending request that must not be accepted
      clearCsrs();
      pmpaddr[0] = 32'h400;
      pmpaddr[3] = 32'h400;
      pmpcfg[0]  = 32'h1100_0013;
      applyStimulus("prio_bp", 32'h1000, 2'b00, 2'b00, 1'b1, 4'd0, 1'b1, 5, 1'b1);

      // Flush in IDLE blocks acceptance
      clearCsrs();
      @(negedge clock);
      flush = 1'b1;
      req_valid = 1'b1;
      @(posedge clock);
      #1;
      checkOutput("flush_idle_ready", 32'(req_ready), 32'd1);
      flush = 1'b0;
      req_valid = 1'b0;

      // Flush mid-scan at index 5
      @(negedge clock);
      req_addr = 32'h1000;
      req_type = 2'b00;
      priv_mode = 2'b00;
      req_valid = 1'b1;
      @(posedge clock);
      #1 req_valid = 1'b0;
      repeat (5) @(posedge clock);
      @(negedge clock);
      flush = 1'b1;
      @(posedge clock);
      #1 flush = 1'b0;
      checkOutput("flush_scan_ready", 32'(req_ready), 32'd1);
      seen = 0;
      repeat (20) begin
         @(posedge clock);
         #1 if (resp_valid) seen++;
      end
      checkOutput("flush_no_resp", 32'(seen), 32'd0);
      pmpcfg[0]  = 32'h0011_0000;
      pmpaddr[2] = 32'h0000_0400;
      applyStimulus("after_flush", 32'h1000, 2'b00, 2'b00, 1'b1, 4'd2, 1'b1, 0, 1'b0);

      // Asynchronous reset mid-scan at index 7
      clearCsrs();
      @(negedge clock);
      req_addr = 32'h1000;
      req_valid = 1'b1;
      @(posedge clock);
      #1 req_valid = 1'b0;
      repeat (7) @(posedge clock);
      #2 reset = 1'b1;
      #1;
      checkOutput("midrst_ready", 32'(req_ready), 32'd1);
      checkOutput("midrst_valid", 32'(resp_valid), 32'd0);
      checkOutput("midrst_data",  {28'd0, resp_hit, resp_allow, 2'b00} | 32'(resp_idx), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      checkOutput("midrst_release_ready", 32'(req_ready), 32'd1);
      applyStimulus("after_rst", 32'h2000, 2'b00, 2'b00, 1'b0, 4'd0, 1'b0, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
